// File: rtl/gcd_controller.sv
// Control FSM for a subtract-and-compare GCD datapath.
// Define GCD_CTRL_WDOG_EN to add the iteration watchdog (err, iter_cnt).
module gcd_controller #(
    parameter logic [15:0] MAX_ITER = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        gt,
    input  logic        lt,
    input  logic        eq,
    output logic        lda,
    output logic        ldb,
    output logic        sel1,
    output logic        sel2,
    output logic        sel_in,
    output logic        busy,
`ifdef GCD_CTRL_WDOG_EN
    output logic        err,
    output logic [15:0] iter_cnt,
`endif
    output logic        done
);

`ifdef GCD_CTRL_WDOG_EN
    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, COMPUTE, DONE, ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, COMPUTE, DONE
    } state_t;
`endif

    state_t state, next;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

`ifdef GCD_CTRL_WDOG_EN
    logic step;
    logic wdog_hit;

    assign wdog_hit = (iter_cnt == MAX_ITER);

    // Counter survives DONE/ERR so the last run can still be read out.
    always_ff @(posedge clk) begin
        if (rst)
            iter_cnt <= '0;
        else if (state == IDLE && start)
            iter_cnt <= '0;
        else if (step)
            iter_cnt <= iter_cnt + 16'd1;
    end

    assign err = (state == ERR);
`endif

    always_comb begin
        next   = state;
        lda    = 1'b0;
        ldb    = 1'b0;
        sel1   = 1'b0;
        sel2   = 1'b0;
        sel_in = 1'b0;
`ifdef GCD_CTRL_WDOG_EN
        step   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (start) next = LOAD_A;
            end
            LOAD_A: begin
                lda    = 1'b1;
                sel_in = 1'b1;
                next   = LOAD_B;
            end
            LOAD_B: begin
                ldb    = 1'b1;
                sel_in = 1'b1;
                next   = COMPUTE;
            end
            COMPUTE: begin
                if (eq) begin
                    next = DONE;
`ifdef GCD_CTRL_WDOG_EN
                end else if (wdog_hit) begin
                    next = ERR;
`endif
                end else if (gt) begin
                    lda  = 1'b1;
                    sel2 = 1'b1;
`ifdef GCD_CTRL_WDOG_EN
                    step = 1'b1;
`endif
                end else if (lt) begin
                    ldb  = 1'b1;
                    sel1 = 1'b1;
`ifdef GCD_CTRL_WDOG_EN
                    step = 1'b1;
`endif
                end
            end
            DONE: next = IDLE;
`ifdef GCD_CTRL_WDOG_EN
            ERR:  next = IDLE;
`endif
            default: next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
`ifdef GCD_CTRL_WDOG_EN
    assign done = (state == DONE) || (state == ERR);
`else
    assign done = (state == DONE);
`endif

endmodule

// File: tb/tb_gcd_controller.sv
// Scoreboard bench for gcd_controller with a behavioural datapath.
// Watchdog scenario is built when GCD_CTRL_WDOG_EN is defined.
module tb_gcd_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        gt, lt, eq;
    logic        lda, ldb, sel1, sel2, sel_in, busy, done;
`ifdef GCD_CTRL_WDOG_EN
    logic        err;
    logic [15:0] iter_cnt;
`endif

    logic [15:0] ra = '0;
    logic [15:0] rb = '0;
    logic [15:0] din = '0;
    logic        force_en = 1'b0;
    logic [2:0]  fflags = 3'b000;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] g;
        int          n;
    } exp_t;
    exp_t sb[$];

    gcd_controller #(.MAX_ITER(16'd4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .gt(gt), .lt(lt), .eq(eq),
        .lda(lda), .ldb(ldb), .sel1(sel1), .sel2(sel2),
        .sel_in(sel_in), .busy(busy),
`ifdef GCD_CTRL_WDOG_EN
        .err(err), .iter_cnt(iter_cnt),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    // Datapath: subtractor, input mux, A/B registers, comparator.
    wire [15:0] minu = sel1 ? rb : ra;
    wire [15:0] subt = sel2 ? rb : ra;
    wire [15:0] bus  = sel_in ? din : (minu - subt);

    assign gt = force_en ? fflags[2] : (ra > rb);
    assign lt = force_en ? fflags[1] : (ra < rb);
    assign eq = force_en ? fflags[0] : (ra == rb);

    always @(posedge clk) begin
        if (lda) ra <= bus;
        if (ldb) rb <= bus;
    end

    // Euclid by repeated subtraction; n counts subtractions.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [15:0] x, y;
        x = a; y = b; e.n = 0;
        while (x != y && x != 0 && y != 0) begin
            if (x > y) x = x - y;
            else       y = y - x;
            e.n++;
        end
        e.g = x;
        return e;
    endfunction

    // Caller sits at a negedge in IDLE; returns at negedge of LOAD_B (cycle 2).
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        din   = a;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        din = b;
    endtask

    task automatic wait_done(output int lat, output bit busy_ok, output bit tmo);
        int k;
        k = 2;
        busy_ok = 1'b1;
        tmo = 1'b0;
        forever begin
            @(negedge clk);
            k++;
            if (!busy) busy_ok = 1'b0;
            if (done) break;
            if (k > 300) begin
                tmo = 1'b1;
                break;
            end
        end
        lat = k;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({lda, ldb, sel1, sel2, sel_in, busy, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {lda, ldb, sel1, sel2, sel_in, busy, done});
        end
`ifdef GCD_CTRL_WDOG_EN
        n_checks++;
        if ({err, iter_cnt} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_wdog err=%b iter=%0d exp 0/0", err, iter_cnt);
        end
`endif
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t e;
        logic [4:0] ctl;
        sb.push_back(model(16'd12, 16'd8));
        launch(16'd12, 16'd8);
        @(negedge clk);
        ctl = {lda, ldb, sel1, sel2, sel_in};
        n_checks++;
        if (ctl !== 5'b10010 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_c3 ctl=%b done=%b exp=10010/0", ctl, done);
        end
        @(negedge clk);
        ctl = {lda, ldb, sel1, sel2, sel_in};
        n_checks++;
        if (ctl !== 5'b01100) begin
            n_fail++;
            $display("FAIL basic_c4 ctl=%b exp=01100", ctl);
        end
        @(negedge clk);
        ctl = {lda, ldb, sel1, sel2, sel_in};
        n_checks++;
        if (ctl !== 5'b00000 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_c5 ctl=%b busy=%b done=%b exp=0/1/0",
                     ctl, busy, done);
        end
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || ra !== e.g || rb !== e.g) begin
            n_fail++;
            $display("FAIL basic_c6 done=%b busy=%b A=%0d B=%0d exp 1/1/%0d",
                     done, busy, ra, rb, e.g);
        end
`ifdef GCD_CTRL_WDOG_EN
        n_checks++;
        if (iter_cnt !== 16'(e.n) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_iter got=%0d err=%b exp=%0d/0", iter_cnt, err, e.n);
        end
`endif
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle busy=%b done=%b exp=0/0", busy, done);
        end
    endtask

    task automatic test_equal();
        exp_t e;
        int lat;
        bit bok, tmo;
        sb.push_back(model(16'd7, 16'd7));
        launch(16'd7, 16'd7);
        wait_done(lat, bok, tmo);
        e = sb.pop_front();
        n_checks++;
        if (tmo || lat !== 4 + e.n || ra !== e.g || rb !== e.g) begin
            n_fail++;
            $display("FAIL equal lat=%0d A=%0d B=%0d exp %0d/%0d",
                     lat, ra, rb, 4 + e.n, e.g);
        end
`ifdef GCD_CTRL_WDOG_EN
        n_checks++;
        if (iter_cnt !== 16'(e.n)) begin
            n_fail++;
            $display("FAIL equal_iter got=%0d exp=%0d", iter_cnt, e.n);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int lat;
        bit bok, tmo;
        sb.push_back(model(16'd35, 16'd14));
        launch(16'd35, 16'd14);
        start = 1'b1;
        wait_done(lat, bok, tmo);
        e = sb.pop_front();
        n_checks++;
        if (tmo || !bok || lat !== 4 + e.n || ra !== e.g || rb !== e.g) begin
            n_fail++;
            $display("FAIL ignore_start lat=%0d busy_ok=%b A=%0d B=%0d exp %0d/1/%0d",
                     lat, bok, ra, rb, 4 + e.n, e.g);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || lda !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_idle busy=%b lda=%b exp=0/0", busy, lda);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int lat;
        bit bok, tmo;
        launch(16'd100, 16'd75);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({lda, ldb, sel1, sel2, sel_in, busy, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_reset outputs=%b exp=0",
                     {lda, ldb, sel1, sel2, sel_in, busy, done});
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        sb.push_back(model(16'd100, 16'd75));
        launch(16'd100, 16'd75);
        wait_done(lat, bok, tmo);
        e = sb.pop_front();
        n_checks++;
        if (tmo || lat !== 4 + e.n || ra !== e.g || rb !== e.g) begin
            n_fail++;
            $display("FAIL mid_reset_rerun lat=%0d A=%0d B=%0d exp %0d/%0d",
                     lat, ra, rb, 4 + e.n, e.g);
        end
        @(negedge clk);
    endtask

    task automatic test_forced_flags();
        force_en = 1'b1;
        fflags = 3'b111;
        launch(16'd9, 16'd3);
        @(negedge clk);
        n_checks++;
        if (lda !== 1'b0 || ldb !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL flags_all lda=%b ldb=%b done=%b exp=0/0/0", lda, ldb, done);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL flags_all_done got=%b exp=1", done);
        end
        @(negedge clk);
        fflags = 3'b000;
        launch(16'd9, 16'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ({lda, ldb, busy, done} !== 4'b0010) begin
                n_fail++;
                $display("FAIL flags_none c%0d lda/ldb/busy/done=%b exp=0010",
                         i + 3, {lda, ldb, busy, done});
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        force_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_operand();
        int lat;
        bit bok, tmo;
        launch(16'd0, 16'd5);
`ifdef GCD_CTRL_WDOG_EN
        wait_done(lat, bok, tmo);
        n_checks++;
        if (tmo || lat !== 8 || err !== 1'b1 || iter_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL wdog lat=%0d err=%b iter=%0d exp 8/1/4", lat, err, iter_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b0 || iter_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL wdog_idle busy=%b err=%b iter=%0d exp 0/0/4",
                     busy, err, iter_cnt);
        end
`else
        lat = 0;
        bok = 1'b1;
        tmo = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) tmo = 1'b1;
            if (!busy || !ldb) bok = 1'b0;
        end
        n_checks++;
        if (tmo || !bok || rb !== 16'd5) begin
            n_fail++;
            $display("FAIL zero_operand done_seen=%b stuck_ok=%b B=%0d exp 0/1/5",
                     tmo, bok, rb);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_operand_rst busy=%b exp=0", busy);
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_back_to_back();
        logic [15:0] av [3];
        logic [15:0] bv [3];
        exp_t e;
        int lat;
        bit bok, tmo;
        av = '{16'd6, 16'd9, 16'd5};
        bv = '{16'd4, 16'd6, 16'd15};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(model(av[i], bv[i]));
            launch(av[i], bv[i]);
            wait_done(lat, bok, tmo);
            e = sb.pop_front();
            n_checks++;
            if (tmo || !bok || lat !== 4 + e.n || ra !== e.g || rb !== e.g) begin
                n_fail++;
                $display("FAIL b2b[%0d] lat=%0d A=%0d B=%0d exp %0d/%0d",
                         i, lat, ra, rb, 4 + e.n, e.g);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_equal();
        test_ignore_start();
        test_mid_reset();
        test_forced_flags();
        test_zero_operand();
        test_back_to_back();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
